// File: rtl/bist_sig_ctrl_pkg.sv
// Shared types and default sizing for the BIST signature controller slice.
package bist_pkg;

  localparam int unsigned BIST_N      = 64;
  localparam int unsigned BIST_CNT_W  = 16;
  localparam int unsigned BIST_TO_CYC = 1024;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } bist_state_e;

endpackage

// File: rtl/bist_sig_ctrl_if.sv
// Configuration, CUT response and status bundle between the test controller and bist_sig_ctrl.
interface bist_sig_ctrl_if import bist_pkg::*; #(
  parameter int unsigned N     = BIST_N,
  parameter int unsigned CNT_W = BIST_CNT_W
) ();

  logic             start_i;
  logic             abort_i;
  logic [CNT_W-1:0] cycles_i;
  logic [N-1:0]     seed_i;
  logic [N-1:0]     coeff_i;
  logic [N-1:0]     golden_i;
  logic [N-1:0]     data_i;
  logic             data_valid_i;
  logic             cut_en_o;
  logic             busy_o;
  logic             done_o;
  logic             pass_o;
  logic             timeout_o;
  logic [N-1:0]     sig_o;
  logic [CNT_W-1:0] remain_o;

  modport master (
    output start_i, abort_i, cycles_i, seed_i, coeff_i, golden_i, data_i, data_valid_i,
    input  cut_en_o, busy_o, done_o, pass_o, timeout_o, sig_o, remain_o
  );

  modport slave (
    input  start_i, abort_i, cycles_i, seed_i, coeff_i, golden_i, data_i, data_valid_i,
    output cut_en_o, busy_o, done_o, pass_o, timeout_o, sig_o, remain_o
  );

endinterface

// File: rtl/bist_sig_ctrl_misr.sv
// Multiple-input signature register: synchronous seed load, compaction enable, programmable taps.
module bist_misr import bist_pkg::*; #(
  parameter int unsigned N = BIST_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [N-1:0] seed,
  input  logic [N-1:0] coeff,
  input  logic [N-1:0] data,
  output logic [N-1:0] sig
);

  logic [N-1:0] sig_q;
  logic [N-1:0] sig_next;

  // Shift left by one with the MSB fed back through the coefficient taps.
  always_comb begin
    sig_next = data ^ (coeff & {N{sig_q[N-1]}}) ^ {sig_q[N-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= N'(1);
    end else if (load) begin
      sig_q <= seed;
    end else if (en) begin
      sig_q <= sig_next;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_sig_ctrl.sv
// BIST session controller: seed, compact N-bit CUT responses, compare with golden signature.
// Optional idle-beat watchdog enabled by defining BIST_TIMEOUT_EN.
module bist_sig_ctrl import bist_pkg::*; #(
  parameter int unsigned N      = BIST_N,
  parameter int unsigned CNT_W  = BIST_CNT_W,
  parameter int unsigned TO_CYC = BIST_TO_CYC
) (
  input logic            clk,
  input logic            rst_n,
  bist_sig_ctrl_if.slave bus
);

  bist_state_e      state_q, state_d;
  logic [CNT_W-1:0] cycles_q;
  logic [CNT_W-1:0] remain_q;
  logic [N-1:0]     seed_q;
  logic [N-1:0]     coeff_q;
  logic [N-1:0]     golden_q;
  logic [N-1:0]     sig;
  logic             start_acc;
  logic             seed_ld;
  logic             misr_en;
  logic             to_fire;
  logic             pass_q;
  logic             cut_en_q;
  logic             busy_q;
  logic             done_q;

`ifdef BIST_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TO_CYC + 1);
  logic [IDLE_W-1:0] idle_q;
  logic              timeout_q;
`else
  localparam int unsigned UNUSED_TO_CYC = TO_CYC;
`endif

  // abort_i wins over start_i and data_valid_i in every state.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    seed_ld   = 1'b0;
    misr_en   = 1'b0;
    to_fire   = 1'b0;
    if (bus.abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start_i) begin
            start_acc = 1'b1;
            state_d   = SEED;
          end
        end
        SEED: begin
          seed_ld = 1'b1;
          state_d = (cycles_q == '0) ? CHECK : RUN;
        end
        RUN: begin
          if (bus.data_valid_i) begin
            misr_en = 1'b1;
            if (remain_q == CNT_W'(1)) state_d = CHECK;
          end
`ifdef BIST_TIMEOUT_EN
          else if (idle_q == IDLE_W'(TO_CYC - 1)) begin
            to_fire = 1'b1;
            state_d = DONE;
          end
`endif
        end
        CHECK:   state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cycles_q <= '0;
      seed_q   <= '0;
      coeff_q  <= '0;
      golden_q <= '0;
      remain_q <= '0;
      pass_q   <= 1'b0;
      cut_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cut_en_q <= (state_d == RUN);
      busy_q   <= (state_d == SEED) || (state_d == RUN) || (state_d == CHECK);
      done_q   <= (state_d == DONE);
      if (start_acc) begin
        cycles_q <= bus.cycles_i;
        seed_q   <= bus.seed_i;
        coeff_q  <= bus.coeff_i;
        golden_q <= bus.golden_i;
      end
      if (seed_ld) begin
        remain_q <= cycles_q;
      end else if (misr_en) begin
        remain_q <= remain_q - CNT_W'(1);
      end
      if (start_acc || to_fire) begin
        pass_q <= 1'b0;
      end else if (state_q == CHECK && !bus.abort_i) begin
        pass_q <= (sig == golden_q);
      end
    end
  end

`ifdef BIST_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == RUN && !bus.data_valid_i && !bus.abort_i) begin
        idle_q <= idle_q + IDLE_W'(1);
      end else begin
        idle_q <= '0;
      end
      if (start_acc) begin
        timeout_q <= 1'b0;
      end else if (to_fire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  assign bus.timeout_o = 1'b0;
`endif

  bist_misr #(.N(N)) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (seed_ld),
    .en    (misr_en),
    .seed  (seed_q),
    .coeff (coeff_q),
    .data  (bus.data_i),
    .sig   (sig)
  );

  assign bus.cut_en_o = cut_en_q;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.pass_o   = pass_q;
  assign bus.sig_o    = sig;
  assign bus.remain_o = remain_q;

endmodule

// File: tb/tb_bist_sig_ctrl.sv
// Directed scoreboard bench for bist_sig_ctrl at N=4, CNT_W=8, TO_CYC=8.
module tb_bist_sig_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bist_sig_ctrl_if #(.N(4), .CNT_W(8)) bus ();

  bist_sig_ctrl #(.N(4), .CNT_W(8), .TO_CYC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] sig;
    logic       pass;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  function automatic logic [3:0] model_step(input logic [3:0] q, input logic [3:0] c,
                                            input logic [3:0] d);
    logic [3:0] r;
    r[0] = d[0] ^ (c[0] & q[3]);
    for (int k = 1; k < 4; k++) r[k] = d[k] ^ (c[k] & q[3]) ^ q[k-1];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sig"},     64'(bus.sig_o),     64'h1);
    check({tag, "_remain"},  64'(bus.remain_o),  64'h0);
    check({tag, "_cut_en"},  64'(bus.cut_en_o),  64'h0);
    check({tag, "_busy"},    64'(bus.busy_o),    64'h0);
    check({tag, "_done"},    64'(bus.done_o),    64'h0);
    check({tag, "_pass"},    64'(bus.pass_o),    64'h0);
    check({tag, "_timeout"}, 64'(bus.timeout_o), 64'h0);
  endtask

  task automatic idle_inputs();
    bus.start_i      = 1'b0;
    bus.abort_i      = 1'b0;
    bus.data_valid_i = 1'b0;
    bus.data_i       = '0;
  endtask

  // Drive start at a negedge; returns after the accepting edge (edge 0).
  task automatic drive_start(input logic [3:0] seed, input logic [3:0] coeff,
                             input logic [3:0] golden, input logic [7:0] ncyc);
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.seed_i   = seed;
    bus.coeff_i  = coeff;
    bus.golden_i = golden;
    bus.cycles_i = ncyc;
    @(posedge clk);
  endtask

  // gap_mask bit i set means no valid beat in cycle i+2 (the i-th RUN cycle).
  task automatic run_session(input string tag, input logic [3:0] seed, input logic [3:0] coeff,
                             input logic [3:0] golden, input logic [7:0] ncyc,
                             input logic [15:0] gap_mask, input bit rnd, input bit poke_start);
    logic [3:0] m;
    int beats;
    int done_at;
    bit cut_seen;
    exp_t e;
    m = seed;
    beats = 0;
    done_at = -1;
    cut_seen = 1'b0;
    drive_start(seed, coeff, golden, ncyc);
    if (ncyc == 0) sb.push_back('{m, m == golden, 3});
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.done_o) begin
        done_at = c;
        break;
      end
      if (bus.cut_en_o) cut_seen = 1'b1;
      // Scramble live config so only the latched copy can produce the expected result.
      bus.start_i  = poke_start && (c == 3);
      bus.seed_i   = 4'($urandom);
      bus.coeff_i  = 4'($urandom);
      bus.golden_i = 4'($urandom);
      bus.cycles_i = 8'($urandom_range(1, 9));
      if (c >= 2 && beats < int'(ncyc)) begin
        bus.data_valid_i = !gap_mask[c-2];
        bus.data_i       = rnd ? 4'($urandom) : 4'h0;
        if (bus.data_valid_i) begin
          m = model_step(m, coeff, bus.data_i);
          beats++;
          if (beats == int'(ncyc)) sb.push_back('{m, m == golden, c + 2});
        end
      end else begin
        bus.data_valid_i = 1'b1;
        bus.data_i       = 4'($urandom) | 4'h1;
      end
    end
    idle_inputs();
    if (done_at < 0) begin
      check({tag, "_done_wait"}, 64'h0, 64'h1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'h0, 64'h1);
    end else begin
      e = sb.pop_front();
      check({tag, "_sig"},      64'(bus.sig_o),     64'(e.sig));
      check({tag, "_pass"},     64'(bus.pass_o),    64'(e.pass));
      check({tag, "_done_cyc"}, 64'(done_at),       64'(e.done_cyc));
      check({tag, "_busy"},     64'(bus.busy_o),    64'h0);
      check({tag, "_remain"},   64'(bus.remain_o),  64'h0);
      check({tag, "_timeout"},  64'(bus.timeout_o), 64'h0);
      if (ncyc == 0) check({tag, "_cut_never"}, 64'(cut_seen), 64'h0);
    end
  endtask

  logic [3:0] frozen;
  int found;
  int done_at;

  initial begin
    idle_inputs();
    bus.seed_i   = '0;
    bus.coeff_i  = '0;
    bus.golden_i = '0;
    bus.cycles_i = '0;
    #12;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_session("one_pass",  4'b0001, 4'b0011, 4'b0010, 8'd1, 16'h0, 1'b0, 1'b0);
    run_session("one_fail",  4'b1000, 4'b0011, 4'b0010, 8'd1, 16'h0, 1'b0, 1'b0);
    run_session("three_cont", 4'h5, 4'h9, 4'h3, 8'd3, 16'h0, 1'b1, 1'b0);
    run_session("three_gaps", 4'h5, 4'h9, 4'h3, 8'd3, 16'b01010, 1'b1, 1'b1);
    run_session("zero_cyc",  4'hA, 4'h6, 4'hA, 8'd0, 16'h0, 1'b1, 1'b0);
    run_session("five_rnd",  4'h7, 4'hC, 4'h0, 8'd5, 16'b00100, 1'b1, 1'b0);

    // Abort mid-RUN once five beats remain.
    drive_start(4'h5, 4'h9, 4'h0, 8'd10);
    found = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      if (c >= 2 && bus.remain_o == 8'd5) begin
        found = 1;
        break;
      end
      bus.data_valid_i = (c >= 2);
      bus.data_i       = 4'($urandom) | 4'h8;
    end
    check("abort_reach_remain5", 64'(found), 64'h1);
    frozen = bus.sig_o;
    bus.abort_i      = 1'b1;
    bus.start_i      = 1'b1;
    bus.data_valid_i = 1'b1;
    bus.data_i       = 4'hF;
    @(negedge clk);
    check("abort_busy",   64'(bus.busy_o),   64'h0);
    check("abort_done",   64'(bus.done_o),   64'h0);
    check("abort_cut_en", 64'(bus.cut_en_o), 64'h0);
    check("abort_sig",    64'(bus.sig_o),    64'(frozen));
    idle_inputs();
    repeat (3) @(negedge clk);
    check("abort_stay_done", 64'(bus.done_o), 64'h0);
    check("abort_stay_busy", 64'(bus.busy_o), 64'h0);
    run_session("after_abort", 4'h3, 4'h5, 4'hE, 8'd4, 16'h0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of RUN.
    drive_start(4'h3, 4'h5, 4'h0, 8'd6);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.start_i      = 1'b0;
      bus.data_valid_i = 1'b1;
      bus.data_i       = 4'($urandom);
    end
    check("pre_reset_busy", 64'(bus.busy_o), 64'h1);
    #2 rst_n = 1'b0;
    #1 check_reset("mid_reset");
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    run_session("after_reset", 4'h9, 4'h3, 4'h1, 8'd2, 16'h0, 1'b1, 1'b0);

`ifdef BIST_TIMEOUT_EN
    // No valid beats: eight idle RUN cycles (2..9) then DONE in cycle 10.
    drive_start(4'h6, 4'h3, 4'h6, 8'd4);
    done_at = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start_i      = 1'b0;
      bus.data_valid_i = 1'b0;
      if (bus.done_o) begin
        done_at = c;
        break;
      end
    end
    check("to_done_cyc", 64'(done_at),       64'd10);
    check("to_timeout",  64'(bus.timeout_o), 64'h1);
    check("to_pass",     64'(bus.pass_o),    64'h0);
    check("to_sig",      64'(bus.sig_o),     64'h6);
    run_session("after_to", 4'h2, 4'h7, 4'h4, 8'd2, 16'h0, 1'b1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, required finish by 200000");
    $fatal(1, "bench time limit");
  end

endmodule
